uart_rx_cfg: RTL

Parametrised UART receiver, successor to the fixed 8N1 receive path.
- Runtime-programmable baud divisor; compile-time data width, parity mode, stop-bit count and oversample ratio.
- 3-sample majority voting, start-glitch rejection, parity, framing, break and overrun detection.
- Holds each received word behind a valid/ack handshake so slow consumers can drain it.
- Sits between the RXD pad and the command parser / RX FIFO, all in the clk_rx domain.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_os_tick.sv | 41 ++++
 rtl/uart_rx_cfg.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants, receive FSM state encoding and the sampling vote helper.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } rx_state_e;

    // 2-of-3 majority of the three mid-bit samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: latches the baud divisor while the receiver is
// idle and emits one registered tick every div_q cycles (every cycle for 0/1).
module uart_os_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk_rx,
    input  logic             rst_clk_rx,
    input  logic             load,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             term_c;

    // Terminal-count detect; >= keeps the counter bounded if the divisor shrinks.
    always_comb begin
        div_d  = load ? baud_div : div_q;
        term_c = (div_q <= DIV_W'(1)) || (cnt_q >= (div_q - DIV_W'(1)));
        cnt_d  = term_c ? '0 : (cnt_q + DIV_W'(1));
        tick_d = term_c;
    end

    // Divisor, counter and tick registers.
    always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
        if (rst_clk_rx) begin
            div_q  <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with majority-vote sampling, parity/framing/break
// detection and a valid/ack hold register for the received word.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                 clk_rx,
    input  logic                 rst_clk_rx,
    input  logic                 rxd_i,
    input  logic [DIV_W-1:0]     baud_div,
    output logic                 rxd_clk_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frm_err,
    output logic                 par_err,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
    localparam int unsigned MID   = OVERSAMPLE / 2;

    logic                 sync1_q, sync2_q;
    logic                 tick;
    logic                 load_c;

    rx_state_e            state_q, state_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 v0_q, v0_d, v1_q, v1_d;
    logic                 par_bit_q, par_bit_d;
    logic                 all_zero_q, all_zero_d;
    logic                 stop_err_q, stop_err_d;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frm_q, frm_d;
    logic                 par_q, par_d;
    logic                 ovr_q, ovr_d;
    logic                 brk_q, brk_d;

    logic                 vote_c, frm_c, par_c;
    logic                 is_v0_c, is_v1_c, is_vote_c, bit_end_c;
    logic                 complete_c, break_c;

    // Two-flop synchroniser on the raw pin, idling high.
    always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
        if (rst_clk_rx) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
        end
    end

    assign load_c = (state_q == ST_IDLE);

    uart_os_tick #(
        .DIV_W (DIV_W)
    ) u_os_tick (
        .clk_rx     (clk_rx),
        .rst_clk_rx (rst_clk_rx),
        .load       (load_c),
        .baud_div   (baud_div),
        .tick       (tick)
    );

    // Frame FSM: next state, bit sampling and shift register.
    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        v0_d       = v0_q;
        v1_d       = v1_q;
        par_bit_d  = par_bit_q;
        all_zero_d = all_zero_q;
        stop_err_d = stop_err_q;
        complete_c = 1'b0;
        break_c    = 1'b0;

        vote_c    = maj3(v0_q, v1_q, sync2_q);
        is_v0_c   = (os_cnt_q == OS_W'(MID - 1));
        is_v1_c   = (os_cnt_q == OS_W'(MID));
        is_vote_c = (os_cnt_q == OS_W'(MID + 1));
        bit_end_c = (os_cnt_q == OS_W'(OVERSAMPLE - 1));
        frm_c     = stop_err_q | ~vote_c;

        if (tick) begin
            if ((state_q != ST_IDLE) && (state_q != ST_BRK_WAIT)) begin
                if (is_v0_c) v0_d = sync2_q;
                if (is_v1_c) v1_d = sync2_q;
                os_cnt_d = bit_end_c ? '0 : (os_cnt_q + OS_W'(1));
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (!sync2_q) begin
                        state_d  = ST_START;
                        os_cnt_d = '0;
                    end
                end
                ST_START: begin
                    if (is_vote_c && vote_c) begin
                        state_d  = ST_IDLE;
                        os_cnt_d = '0;
                    end else if (bit_end_c) begin
                        state_d    = ST_DATA;
                        bit_cnt_d  = '0;
                        all_zero_d = 1'b1;
                        stop_err_d = 1'b0;
                    end
                end
                ST_DATA: begin
                    if (is_vote_c) begin
                        shift_d    = {vote_c, shift_q[DATA_BITS-1:1]};
                        all_zero_d = all_zero_q & ~vote_c;
                    end
                    if (bit_end_c) begin
                        if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (is_vote_c) begin
                        par_bit_d  = vote_c;
                        all_zero_d = all_zero_q & ~vote_c;
                    end
                    if (bit_end_c) state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (is_vote_c) begin
                        stop_err_d = frm_c;
                        if ((bit_cnt_q == '0) && all_zero_q && !vote_c) begin
                            break_c  = 1'b1;
                            state_d  = ST_BRK_WAIT;
                            os_cnt_d = '0;
                        end else if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                            complete_c = 1'b1;
                            state_d    = ST_IDLE;
                            os_cnt_d   = '0;
                        end
                    end else if (bit_end_c) begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
                ST_BRK_WAIT: begin
                    // os_cnt counts consecutive high ticks here.
                    if (!sync2_q) begin
                        os_cnt_d = '0;
                    end else if (bit_end_c) begin
                        state_d  = ST_IDLE;
                        os_cnt_d = '0;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    os_cnt_d = '0;
                end
            endcase
        end
    end

    // Parity check over the assembled word and received parity bit.
    always_comb begin
        par_c = 1'b0;
        if (PARITY == PARITY_ODD) begin
            par_c = ~(^shift_q ^ par_bit_q);
        end else if (PARITY == PARITY_EVEN) begin
            par_c = ^shift_q ^ par_bit_q;
        end
    end

    // Output hold register with valid/ack handshake and overrun detect.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        frm_d   = frm_q;
        par_d   = par_q;
        ovr_d   = 1'b0;
        brk_d   = break_c;
        if (complete_c) begin
            data_d  = shift_q;
            frm_d   = frm_c;
            par_d   = par_c;
            valid_d = 1'b1;
            ovr_d   = valid_q & ~rx_ack;
        end else if (rx_ack && valid_q) begin
            valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
        if (rst_clk_rx) begin
            state_q    <= ST_IDLE;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            v0_q       <= 1'b1;
            v1_q       <= 1'b1;
            par_bit_q  <= 1'b0;
            all_zero_q <= 1'b0;
            stop_err_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            frm_q      <= 1'b0;
            par_q      <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            v0_q       <= v0_d;
            v1_q       <= v1_d;
            par_bit_q  <= par_bit_d;
            all_zero_q <= all_zero_d;
            stop_err_q <= stop_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            frm_q      <= frm_d;
            par_q      <= par_d;
            ovr_q      <= ovr_d;
            brk_q      <= brk_d;
        end
    end

    assign rxd_clk_rx = sync2_q;
    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frm_err    = frm_q;
    assign par_err    = par_q;
    assign overrun    = ovr_q;
    assign break_det  = brk_q;

endmodule
